data_mem_param: RTL and testbench
=================================

Name: data_mem_param

Overview:
Parametrised next-generation data memory for the MIPS datapath. It is word-addressed and has per-byte write enables. Reads are registered, with a one-cycle read-valid pulse, and out-of-range accesses are flagged. After every reset, a hardware clear sequencer zeroes the whole array and holds the block busy until the sweep finishes. It sits between the ALU/address path and the writeback mux, and replaces the fixed 16-bit memory.

Parameters:
- DATA_W, 16: word width in bits. Must be a multiple of 8.
- ADDR_W, 16: width of the address port.
- DEPTH, 256: number of words. Legal addresses are 0..DEPTH-1. Must be ≤ 2^ADDR_W.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- address  in  ADDR_W  word address
- write_data  in  DATA_W  store data
- be  in  DATA_W/8  byte-lane write enables; bit i covers bits [8i+7:8i]
- memw  in  1  write request
- memr  in  1  read request
- read_data  out  DATA_W  registered read result
- rvalid  out  1  one-cycle pulse; read_data is valid in that cycle
- busy  out  1  high while the clear sweep runs; requests are ignored while high
- err  out  1  one-cycle pulse on an out-of-range access

Behaviour:
- Reset (rst=1 at a clk edge):
  - read_data=0, rvalid=0, err=0, busy=1.
  - FSM goes to CLEAR and the sweep counter is set to 0.
  - Reset asserted mid-sweep restarts the sweep from 0.
- FSM has two states, CLEAR and READY.
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. After the cycle that writes mem[DEPTH-1], go to READY. busy drops in the first READY cycle, exactly DEPTH cycles after rst deasserts.
  - READY: stays there until rst.
- In CLEAR, memw and memr are ignored: no write, no rvalid, no err. read_data holds 0.
- Write (READY, memw=1, address<DEPTH): at the clk edge, mem[address] lane i takes write_data lane i for every i with be[i]=1. Other lanes are unchanged. be=0 is a legal no-op write with no err.
- Read (READY, memr=1, address<DEPTH):
  - read_data is updated at the clk edge.
  - rvalid=1 for the following cycle, giving 1-cycle latency.
  - With no read, read_data holds its last value and rvalid=0.
- Simultaneous memw and memr to the same address: the write is performed and the read returns the pre-write contents (read-before-write).
- Out-of-range access (address ≥ DEPTH with memw or memr):
  - No array update.
  - If memr was set, read_data=0 and rvalid=1.
  - err=1 for one cycle.
  - Only the low ceil(log2 DEPTH) bits index the array, after the range check; indexes never alias.
- Back-to-back reads on consecutive cycles give consecutive rvalid pulses with no bubble.
- rvalid and err are single-cycle registered pulses and are never held high by a level input.
- Contents persist across idle cycles and are lost only on reset, through the clear sweep.

Test Plan:
- Reset then wait (DEPTH=16): rst for 2 cycles → busy=1 for exactly 16 cycles after release. A read of address 3 issued during busy gives no rvalid. After busy falls, reading address 3 gives read_data=0 and rvalid=1.
- Full write/readback: write 25 (0x0019) to address 4 with be=2'b11, then memr at address 4 → next cycle read_data=0x0019, rvalid=1. Reads of addresses 1, 2, 3 return 0.
- Byte enables: write 0xAABB to address 5 with be=11, then 0x1234 with be=01 → read gives 0xAA34. A further write with be=10 of 0x5600 → read gives 0x5634.
- Same-cycle read/write: mem[6]=0x1111, then memw=memr=1 at address 6 with write_data=0x2222 → read_data=0x1111. The next read gives 0x2222.
- Out of range (DEPTH=16): memw at address 16 with 0xFFFF → err pulse, and mem[0] is still 0. memr at address 20 → read_data=0, rvalid=1, err=1, each for one cycle.
- Reset mid-operation: write 0x00FF to address 2, assert rst 5 cycles into a later sweep → busy restarts for a full 16 cycles, then reading address 2 returns 0.

Source files
------------

// File: rtl/data_mem_param.sv
// Word-addressed data memory with per-byte write enables, registered reads,
// out-of-range flagging and a post-reset clear sweep that holds busy high.
module data_mem_param #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_W-1:0]     address,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [DATA_W/8-1:0]   be,
  input  logic                  memw,
  input  logic                  memr,
  output logic [DATA_W-1:0]     read_data,
  output logic                  rvalid,
  output logic                  busy,
  output logic                  err
);

  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

  localparam logic S_CLEAR = 1'b0;
  localparam logic S_READY = 1'b1;

  logic              state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              rvalid_q, rvalid_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready;
  logic              in_range;
  logic [IDX_W-1:0]  idx;
  logic              wr_en;

  assign ready    = (state_q == S_READY);
  // Range check uses the full address; only then are the low bits trusted as an index.
  assign in_range = ({1'b0, address} < DEPTH_EXT);
  assign idx      = address[IDX_W-1:0];
  assign wr_en    = ready && !rst && memw && in_range;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_CLEAR) begin
      cnt_d = cnt_q + IDX_W'(1);
      if (cnt_q == LAST_IDX) begin
        state_d = S_READY;
      end
    end
  end

  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = ready && memr;
    err_d    = ready && (memr || memw) && !in_range;
    if (ready && memr) begin
      rdata_d = in_range ? mem[idx] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_CLEAR;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Array has no reset; the sweep zeroes it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int unsigned i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem[idx][8*i +: 8] <= write_data[8*i +: 8];
        end
      end
    end
  end

  assign read_data = rdata_q;
  assign rvalid    = rvalid_q;
  assign err       = err_q;
  assign busy      = (state_q == S_CLEAR);

endmodule

// File: tb/tb_data_mem_param.sv
// Bench for data_mem_param: directed scenarios plus randomized traffic checked
// every cycle against an array-based model of the memory.
module tb_data_mem_param;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int DP = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] address;
  logic [DW-1:0] write_data;
  logic [1:0]    be;
  logic          memw, memr;
  logic [DW-1:0] read_data;
  logic          rvalid, busy, err;

  int checks = 0;
  int passes = 0;

  data_mem_param #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .address(address), .write_data(write_data), .be(be),
    .memw(memw), .memr(memr), .read_data(read_data), .rvalid(rvalid),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    else passes++;
  endtask

  // Reference model: plain array, reset wipes it, busy counted as cycles left.
  logic [DW-1:0] model_mem [DP];
  int            sweep_left = 0;
  logic [DW-1:0] exp_rd;
  logic          exp_rv, exp_err;
  logic          started = 1'b0;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [1:0] b);
    logic [DW-1:0] r;
    r = old;
    if (b[0]) r[7:0]  = d[7:0];
    if (b[1]) r[15:8] = d[15:8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      started    <= 1'b1;
      sweep_left <= DP;
      exp_rd     <= '0;
      exp_rv     <= 1'b0;
      exp_err    <= 1'b0;
      for (int i = 0; i < DP; i++) model_mem[i] <= '0;
    end else if (sweep_left > 0) begin
      sweep_left <= sweep_left - 1;
      exp_rv     <= 1'b0;
      exp_err    <= 1'b0;
    end else begin
      exp_rv  <= memr;
      exp_err <= (memr || memw) && (int'(address) >= DP);
      if (memr) exp_rd <= (int'(address) < DP) ? model_mem[int'(address)] : '0;
      if (memw && int'(address) < DP)
        model_mem[int'(address)] <= merge(model_mem[int'(address)], write_data, be);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("busy", 32'(busy), 32'(sweep_left != 0));
      chk("rvalid", 32'(rvalid), 32'(exp_rv));
      chk("err", 32'(err), 32'(exp_err));
      chk("read_data", 32'(read_data), 32'(exp_rd));
    end
  end

  task automatic op(input logic w, input logic r, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [1:0] b);
    @(negedge clk);
    rst = 1'b0; memw = w; memr = r; address = a; write_data = d; be = b;
    @(posedge clk);
    #1;
  endtask

  task automatic reset_cycles(input int n);
    @(negedge clk);
    rst = 1'b1; memw = 1'b0; memr = 1'b0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at the negedge right after rst drops; counts busy-high negedges, bounded.
  task automatic count_busy(output int n);
    n = 0;
    memr = 1'b1; address = 8'd3;
    while (busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    memr = 1'b0;
  endtask

  int n;

  initial begin
    rst = 1'b1; memw = 1'b0; memr = 1'b0; address = '0; write_data = '0; be = '0;

    // Reset then wait; reads during busy must be ignored.
    reset_cycles(2);
    count_busy(n);
    chk("busy_len_initial", 32'(n), 32'd16);
    op(0, 1, 8'd3, 16'h0, 2'b00);
    chk("lit_rd_after_clear", 32'(read_data), 32'h0);
    chk("lit_rv_after_clear", 32'(rvalid), 32'd1);

    // Full write and readback.
    op(1, 0, 8'd4, 16'h0019, 2'b11);
    op(0, 1, 8'd4, 16'h0, 2'b00);
    chk("lit_rd4", 32'(read_data), 32'h0019);
    chk("lit_model_rd4", 32'(exp_rd), 32'h0019);
    for (int a = 1; a <= 3; a++) begin
      op(0, 1, 8'(a), 16'h0, 2'b00);
      chk("lit_rd_zero", 32'(read_data), 32'h0);
    end

    // Byte enables.
    op(1, 0, 8'd5, 16'hAABB, 2'b11);
    op(1, 0, 8'd5, 16'h1234, 2'b01);
    op(0, 1, 8'd5, 16'h0, 2'b00);
    chk("lit_be01", 32'(read_data), 32'hAA34);
    op(1, 0, 8'd5, 16'h5600, 2'b10);
    op(0, 1, 8'd5, 16'h0, 2'b00);
    chk("lit_be10", 32'(read_data), 32'h5634);
    chk("lit_model_be10", 32'(exp_rd), 32'h5634);

    // Same-cycle read/write returns old contents.
    op(1, 0, 8'd6, 16'h1111, 2'b11);
    op(1, 1, 8'd6, 16'h2222, 2'b11);
    chk("lit_rbw_old", 32'(read_data), 32'h1111);
    op(0, 1, 8'd6, 16'h0, 2'b00);
    chk("lit_rbw_new", 32'(read_data), 32'h2222);

    // Out of range.
    op(1, 0, 8'd16, 16'hFFFF, 2'b11);
    chk("lit_oor_w_err", 32'(err), 32'd1);
    chk("lit_oor_w_rv", 32'(rvalid), 32'd0);
    op(0, 1, 8'd0, 16'h0, 2'b00);
    chk("lit_no_alias", 32'(read_data), 32'h0);
    chk("lit_no_alias_err", 32'(err), 32'd0);
    op(0, 1, 8'd20, 16'h0, 2'b00);
    chk("lit_oor_r_rd", 32'(read_data), 32'h0);
    chk("lit_oor_r_rv", 32'(rvalid), 32'd1);
    chk("lit_oor_r_err", 32'(err), 32'd1);
    op(0, 0, 8'd0, 16'h0, 2'b00);
    chk("lit_pulse_rv", 32'(rvalid), 32'd0);
    chk("lit_pulse_err", 32'(err), 32'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 249) == 0) begin
        reset_cycles(1 + $urandom_range(0, 2));
      end else begin
        op(1'($urandom), 1'($urandom), 8'($urandom_range(0, 19)),
           16'($urandom), 2'($urandom));
      end
    end

    // Reset mid-sweep restarts the clear and wipes prior writes.
    reset_cycles(1);
    count_busy(n);
    chk("busy_len_prep", 32'(n), 32'd16);
    op(1, 0, 8'd2, 16'h00FF, 2'b11);
    reset_cycles(1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    count_busy(n);
    chk("busy_len_restart", 32'(n), 32'd16);
    op(0, 1, 8'd2, 16'h0, 2'b00);
    chk("lit_rd2_cleared", 32'(read_data), 32'h0);
    chk("lit_rv2", 32'(rvalid), 32'd1);
    op(0, 0, 8'd0, 16'h0, 2'b00);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "timeout");
  end

endmodule
